// File: rtl/yarvi_mem_pkg.sv
// Shared types for the yarvi data-memory arbiter: requester ids, arbiter
// states and the byte-enable constant used for full-word host writes.
package yarvi_mem_pkg;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_BUS  = 1'b1
    } owner_t;

    typedef enum logic {
        CORE_PRI = 1'b0,
        BUS_PRI  = 1'b1
    } arb_state_t;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam int         CNT_W   = 4;

endpackage

// File: rtl/yarvi_mem_resp_pipe.sv
// Tracks in-flight reads so memory read data is steered back to the requester
// that issued the read, in issue order, three cycles after the grant.
module yarvi_mem_resp_pipe
    import yarvi_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic              issue_bus,
    input  logic [DATA_W-1:0] readdata,
    output logic              core_res_valid,
    output logic [DATA_W-1:0] core_res_data,
    output logic              bus_res_valid,
    output logic [DATA_W-1:0] bus_res_data
);

    // Stage 0 lines up with readenable, stage 1 with readdata.
    logic   [1:0] vld_pipe;
    owner_t [1:0] own_pipe;
    logic         core_hit;
    logic         bus_hit;

    assign core_hit = vld_pipe[1] && (own_pipe[1] == OWN_CORE);
    assign bus_hit  = vld_pipe[1] && (own_pipe[1] == OWN_BUS);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            own_pipe <= {OWN_CORE, OWN_CORE};
        end else begin
            vld_pipe    <= {vld_pipe[0], issue_valid};
            own_pipe[0] <= issue_bus ? OWN_BUS : OWN_CORE;
            own_pipe[1] <= own_pipe[0];
        end
    end

    // Data registers only load on their own response so they hold otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            core_res_valid <= 1'b0;
            core_res_data  <= '0;
            bus_res_valid  <= 1'b0;
            bus_res_data   <= '0;
        end else begin
            core_res_valid <= core_hit;
            bus_res_valid  <= bus_hit;
            if (core_hit) core_res_data <= readdata;
            if (bus_hit)  bus_res_data  <= readdata;
        end
    end

endmodule

// File: rtl/yarvi_mem_arbiter.sv
// Arbitrates the single-port data memory between the core load/store port and
// the host bus, with a starvation counter that eventually favours the bus.
module yarvi_mem_arbiter
    import yarvi_mem_pkg::*;
#(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              core_req_valid,
    input  logic              core_req_write,
    input  logic [ADDR_W-1:0] core_req_addr,
    input  logic [DATA_W-1:0] core_req_data,
    input  logic [3:0]        core_req_be,
    output logic              core_req_ready,
    output logic              core_res_valid,
    output logic [DATA_W-1:0] core_res_data,

    input  logic              bus_req_read,
    input  logic              bus_req_write,
    input  logic [31:0]       bus_req_address,
    input  logic [DATA_W-1:0] bus_req_data,
    output logic              bus_req_ready,
    output logic              bus_res_valid,
    output logic [DATA_W-1:0] bus_res_data,

    output logic [ADDR_W-1:0] address,
    output logic              writeenable,
    output logic [DATA_W-1:0] writedata,
    output logic [3:0]        byteena,
    output logic              readenable,
    input  logic [DATA_W-1:0] readdata
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    logic [1:0]        rst_sync;
    logic              arst_n;
    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_nxt;
    logic              bus_pend;
    logic              core_grant;
    logic              bus_grant;
    logic              any_grant;
    logic              grant_write;
    logic [ADDR_W-1:0] bus_word_addr;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;
    logic [3:0]        grant_be;

    // Reset asserts immediately and releases two clocks after reset_n rises.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign arst_n = rst_sync[1];

    assign bus_pend      = bus_req_read | bus_req_write;
    assign bus_word_addr = ADDR_W'(bus_req_address >> 2);

    always_comb begin
        core_req_ready = 1'b0;
        bus_req_ready  = 1'b0;
        state_nxt      = state;
        starve_nxt     = starve_cnt;
        if (arst_n) begin
            case (state)
                CORE_PRI: begin
                    core_req_ready = 1'b1;
                    bus_req_ready  = bus_pend & ~core_req_valid;
                    if (bus_pend && core_req_valid) begin
                        if (starve_cnt != CNT_SAT) starve_nxt = starve_cnt + 1'b1;
                        if (starve_nxt >= STARVE_LIM) state_nxt = BUS_PRI;
                    end
                    if (bus_req_ready) starve_nxt = '0;
                end
                BUS_PRI: begin
                    // Either the bus takes its one grant or it went away; both end the boost.
                    bus_req_ready  = bus_pend;
                    core_req_ready = ~bus_pend;
                    state_nxt      = CORE_PRI;
                    starve_nxt     = '0;
                end
                default: state_nxt = CORE_PRI;
            endcase
        end
    end

    assign core_grant  = core_req_valid & core_req_ready;
    assign bus_grant   = bus_pend & bus_req_ready;
    assign any_grant   = core_grant | bus_grant;
    assign grant_write = bus_grant ? bus_req_write   : core_req_write;
    assign grant_addr  = bus_grant ? bus_word_addr   : core_req_addr;
    assign grant_data  = bus_grant ? bus_req_data    : core_req_data;
    assign grant_be    = bus_grant ? BE_FULL         : core_req_be;

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            state       <= CORE_PRI;
            starve_cnt  <= '0;
            address     <= '0;
            writedata   <= '0;
            byteena     <= '0;
            writeenable <= 1'b0;
            readenable  <= 1'b0;
        end else begin
            state       <= state_nxt;
            starve_cnt  <= starve_nxt;
            writeenable <= any_grant & grant_write;
            readenable  <= any_grant & ~grant_write;
            if (any_grant) begin
                address   <= grant_addr;
                writedata <= grant_data;
                byteena   <= grant_be;
            end
        end
    end

    yarvi_mem_resp_pipe #(
        .DATA_W (DATA_W)
    ) u_resp_pipe (
        .clock          (clock),
        .reset_n        (arst_n),
        .issue_valid    (any_grant & ~grant_write),
        .issue_bus      (bus_grant),
        .readdata       (readdata),
        .core_res_valid (core_res_valid),
        .core_res_data  (core_res_data),
        .bus_res_valid  (bus_res_valid),
        .bus_res_data   (bus_res_data)
    );

endmodule

// File: tb/tb_yarvi_mem_arbiter.sv
// Bench for yarvi_mem_arbiter: directed vector table, random traffic against a
// transaction-level reference, and a reset-while-reading sequence.
module tb_yarvi_mem_arbiter;

    localparam int ADDR_W     = 30;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clock;
    logic              reset_n;
    logic              core_req_valid, core_req_write;
    logic [ADDR_W-1:0] core_req_addr;
    logic [DATA_W-1:0] core_req_data;
    logic [3:0]        core_req_be;
    logic              core_req_ready, core_res_valid;
    logic [DATA_W-1:0] core_res_data;
    logic              bus_req_read, bus_req_write;
    logic [31:0]       bus_req_address;
    logic [DATA_W-1:0] bus_req_data;
    logic              bus_req_ready, bus_res_valid;
    logic [DATA_W-1:0] bus_res_data;
    logic [ADDR_W-1:0] address;
    logic              writeenable, readenable;
    logic [DATA_W-1:0] writedata, readdata;
    logic [3:0]        byteena;

    yarvi_mem_arbiter #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clock (clock), .reset_n (reset_n),
        .core_req_valid (core_req_valid), .core_req_write (core_req_write),
        .core_req_addr (core_req_addr), .core_req_data (core_req_data),
        .core_req_be (core_req_be), .core_req_ready (core_req_ready),
        .core_res_valid (core_res_valid), .core_res_data (core_res_data),
        .bus_req_read (bus_req_read), .bus_req_write (bus_req_write),
        .bus_req_address (bus_req_address), .bus_req_data (bus_req_data),
        .bus_req_ready (bus_req_ready), .bus_res_valid (bus_res_valid),
        .bus_res_data (bus_res_data),
        .address (address), .writeenable (writeenable), .writedata (writedata),
        .byteena (byteena), .readenable (readenable), .readdata (readdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        cv, cw;
        logic [29:0] ca;
        logic [31:0] cd;
        logic [3:0]  cbe;
        logic        br, bw;
        logic [31:0] ba, bd;
        logic        ecr, ebr;
    } tv_t;

    typedef struct {
        int          due;
        bit          bus;
        logic [31:0] data;
    } rsp_t;

    int n_chk = 0, n_pass = 0, cyc = 0;

    // Environment memory (single port, read data one cycle after readenable)
    logic [31:0] mem [256];
    logic [31:0] rd_pend;

    // Reference model state
    logic [31:0] ref_mem [256];
    bit          bprio;
    int          lost;
    rsp_t        rq[$];
    logic        m_we, m_re;
    logic [29:0] m_addr;
    logic [31:0] m_wd, m_cdata, m_bdata;
    logic [3:0]  m_be;

    tv_t tv[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic tv_t mk(logic cv, logic cw, logic [29:0] ca, logic [31:0] cd,
                               logic [3:0] cbe, logic br, logic bw, logic [31:0] ba,
                               logic [31:0] bd, logic ecr, logic ebr);
        tv_t t;
        t.cv = cv; t.cw = cw; t.ca = ca; t.cd = cd; t.cbe = cbe;
        t.br = br; t.bw = bw; t.ba = ba; t.bd = bd; t.ecr = ecr; t.ebr = ebr;
        return t;
    endfunction

    task automatic drive(input tv_t r);
        core_req_valid  = r.cv;  core_req_write = r.cw; core_req_addr = r.ca;
        core_req_data   = r.cd;  core_req_be    = r.cbe;
        bus_req_read    = r.br;  bus_req_write  = r.bw;
        bus_req_address = r.ba;  bus_req_data   = r.bd;
    endtask

    // Advance to the next falling edge and play the memory's side of the port.
    task automatic tick();
        logic [31:0] w;
        @(negedge clock);
        readdata = rd_pend;
        if (readenable) rd_pend = mem[address[7:0]];
        if (writeenable) begin
            w = mem[address[7:0]];
            for (int b = 0; b < 4; b++) if (byteena[b]) w[8*b +: 8] = writedata[8*b +: 8];
            mem[address[7:0]] = w;
        end
    endtask

    task automatic model_reset();
        bprio = 0; lost = 0; rq.delete();
        m_we = 0; m_re = 0; m_addr = '0; m_wd = '0; m_be = '0;
        m_cdata = '0; m_bdata = '0;
    endtask

    task automatic step(input tv_t r);
        logic e_cv, e_bv, bp, ecr, ebr, cg, bg, w;
        logic [29:0] a;
        logic [31:0] d, nv;
        logic [3:0]  be;
        rsp_t        rs;
        tick();
        chk("writeenable", writeenable, m_we);
        chk("readenable", readenable, m_re);
        chk("address", address, m_addr);
        chk("writedata", writedata, m_wd);
        chk("byteena", byteena, m_be);
        e_cv = 0; e_bv = 0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            rs = rq.pop_front();
            if (rs.bus) begin e_bv = 1; m_bdata = rs.data; end
            else        begin e_cv = 1; m_cdata = rs.data; end
        end
        chk("core_res_valid", core_res_valid, e_cv);
        chk("bus_res_valid", bus_res_valid, e_bv);
        chk("core_res_data", core_res_data, m_cdata);
        chk("bus_res_data", bus_res_data, m_bdata);
        drive(r);
        #1;
        bp = r.br | r.bw;
        if (!bprio) begin ecr = 1; ebr = bp & ~r.cv; end
        else        begin ebr = bp; ecr = ~bp; end
        chk("core_req_ready", core_req_ready, ecr);
        chk("bus_req_ready", bus_req_ready, ebr);
        cg = r.cv & ecr;
        bg = bp & ebr;
        if (bprio) begin
            bprio = 0; lost = 0;
        end else begin
            if (bp && r.cv) begin
                lost = (lost < 15) ? lost + 1 : 15;
                if (lost >= STARVE_MAX) bprio = 1;
            end
            if (bg) lost = 0;
        end
        m_we = 0; m_re = 0;
        if (cg || bg) begin
            w  = bg ? r.bw : r.cw;
            a  = bg ? r.ba[31:2] : r.ca;
            d  = bg ? r.bd : r.cd;
            be = bg ? 4'hF : r.cbe;
            m_addr = a; m_wd = d; m_be = be;
            if (w) begin
                m_we = 1;
                nv = ref_mem[a[7:0]];
                for (int b = 0; b < 4; b++) if (be[b]) nv[8*b +: 8] = d[8*b +: 8];
                ref_mem[a[7:0]] = nv;
            end else begin
                m_re = 1;
                rq.push_back('{due: cyc + 3, bus: bg, data: ref_mem[a[7:0]]});
            end
        end
        cyc++;
    endtask

    initial begin
        tv_t idle, r;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        rd_pend = '0; readdata = '0;
        for (int i = 0; i < 256; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
        model_reset();

        // Reset state, with both requesters asking
        reset_n = 1'b0;
        drive(mk(1, 0, 30'h10, 0, 0, 1, 0, 32'h40, 0, 0, 0));
        tick(); tick(); #1;
        chk("rst_core_req_ready", core_req_ready, 0);
        chk("rst_bus_req_ready", bus_req_ready, 0);
        chk("rst_strobes", {writeenable, readenable}, 0);
        chk("rst_address", address, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_byteena", byteena, 0);
        chk("rst_res_valid", {core_res_valid, bus_res_valid}, 0);
        chk("rst_res_data", {core_res_data, bus_res_data}, 0);
        drive(idle);
        reset_n = 1'b1;
        tick(); tick(); tick();

        // Directed vectors: {inputs, expected core_req_ready, bus_req_ready}
        tv.push_back(mk(1, 0, 30'h10, 0, 0, 0, 0, 0, 0, 1, 0));           // core load
        repeat (3) tv.push_back(idle);
        tv.push_back(mk(1, 1, 30'h4, 32'h12345678, 4'b0011, 0, 0, 0, 0, 1, 0)); // core store
        repeat (2) tv.push_back(idle);
        for (int i = 0; i < 4; i++)                                        // bus starved
            tv.push_back(mk(1, 0, 30'h20 + 30'(i), 0, 0, 1, 0, 32'h40, 0, 1, 0));
        tv.push_back(mk(1, 0, 30'h24, 0, 0, 1, 0, 32'h40, 0, 0, 1));       // 5th cycle: bus wins
        tv.push_back(mk(1, 0, 30'h24, 0, 0, 0, 0, 0, 0, 1, 0));
        repeat (3) tv.push_back(idle);
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h80, 32'hA5A5A5A5, 1, 1)); // rd+wr: write wins
        repeat (3) tv.push_back(idle);
        for (int i = 0; i < 3; i++) begin                                  // alternating reads
            tv.push_back(mk(1, 0, 30'h11 + 30'(2 * i), 0, 0, 0, 0, 0, 0, 1, 0));
            tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h48 + 32'(8 * i), 0, 1, 1));
        end
        tv.push_back(mk(1, 1, 30'h30, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 1, 0)); // RAW
        tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'hC0, 0, 1, 1));
        tv.push_back(mk(1, 1, 30'h30, 32'h00770000, 4'b0100, 0, 0, 0, 0, 1, 0));
        tv.push_back(mk(1, 0, 30'h30, 0, 0, 0, 0, 0, 0, 1, 0));
        repeat (4) tv.push_back(idle);
        foreach (tv[i]) begin
            step(tv[i]);
            chk("tbl_core_req_ready", core_req_ready, tv[i].ecr);
            chk("tbl_bus_req_ready", bus_req_ready, tv[i].ebr);
        end

        // Random traffic over a small address window to force collisions
        for (int i = 0; i < 400; i++) begin
            r = idle;
            r.cv  = ($urandom_range(0, 2) != 0);
            r.cw  = $urandom_range(0, 1);
            r.ca  = 30'($urandom_range(0, 15));
            r.cd  = $urandom;
            r.cbe = 4'($urandom_range(0, 15));
            r.br  = ($urandom_range(0, 2) == 0);
            r.bw  = ($urandom_range(0, 3) == 0);
            r.ba  = {22'h0, 4'($urandom_range(0, 15)) + 8'h0, 2'b00};
            r.bd  = $urandom;
            step(r);
        end
        repeat (4) step(idle);

        // Reset one cycle after a read grant: everything drops, nothing returns
        step(mk(1, 0, 30'h10, 0, 0, 0, 0, 0, 0, 1, 0));
        tick();
        reset_n = 1'b0;
        drive(mk(1, 0, 30'h12, 0, 0, 1, 0, 32'h40, 0, 0, 0));
        #1;
        chk("midrst_ready", {core_req_ready, bus_req_ready}, 0);
        chk("midrst_strobes", {writeenable, readenable}, 0);
        chk("midrst_address", address, 0);
        chk("midrst_res_valid", {core_res_valid, bus_res_valid}, 0);
        chk("midrst_res_data", {core_res_data, bus_res_data}, 0);
        tick();
        drive(idle);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk("post_rst_res_valid", {core_res_valid, bus_res_valid}, 0);
        end
        model_reset();
        step(mk(1, 0, 30'h10, 0, 0, 0, 0, 0, 0, 1, 0));
        repeat (4) step(idle);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
